// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 16:1 mux: steps the select through all 16 channels,
// samples the mux output after a settling dwell and publishes the assembled word.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic        abort,
    input  logic        f,
    output logic [3:0]  sw,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout
);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(DWELL - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_sw, w_sw_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_shadow, w_shadow_nxt;
    logic [15:0] r_dout, w_dout_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sw     <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_dout   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sw     <= w_sw_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_dout   <= w_dout_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sw_nxt     = r_sw;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_dout_nxt   = r_dout;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        // abort wins over start and over a coinciding last-channel sample
        if (abort) begin
            w_state_nxt = IDLE;
            w_sw_nxt    = '0;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = SETTLE;
                        w_sw_nxt    = '0;
                        w_cnt_nxt   = CNT_INIT;
                        w_busy_nxt  = 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_shadow_nxt[r_sw] = f;
                        w_cnt_nxt          = CNT_INIT;
                        if (r_sw != 4'd15) begin
                            w_sw_nxt = r_sw + 4'd1;
                        end else begin
                            // final bit goes straight into dout, bypassing the shadow
                            w_dout_nxt = {f, r_shadow[14:0]};
                            w_done_nxt = 1'b1;
                            w_sw_nxt   = '0;
                            if (!cont) begin
                                w_state_nxt = IDLE;
                                w_busy_nxt  = 1'b0;
                            end
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign sw   = r_sw;
    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (DWELL=2 and DWELL=1),
// each driven by a behavioural 16:1 mux model fed from a static input word.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_start = 1'b0, a_cont = 1'b0, a_abort = 1'b0, a_f;
    logic [3:0]  a_sw;
    logic        a_busy, a_done;
    logic [15:0] a_dout;
    logic [15:0] a_in = '0;

    logic        b_start = 1'b0, b_cont = 1'b0, b_abort = 1'b0, b_f;
    logic [3:0]  b_sw;
    logic        b_busy, b_done;
    logic [15:0] b_dout;
    logic [15:0] b_in = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign a_f = a_in[a_sw];
    assign b_f = b_in[b_sw];

    mux_scan_ctrl #(.DWELL(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (a_start),
        .cont  (a_cont),
        .abort (a_abort),
        .f     (a_f),
        .sw    (a_sw),
        .busy  (a_busy),
        .done  (a_done),
        .dout  (a_dout)
    );

    mux_scan_ctrl #(.DWELL(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (b_start),
        .cont  (b_cont),
        .abort (b_abort),
        .f     (b_f),
        .sw    (b_sw),
        .busy  (b_busy),
        .done  (b_done),
        .dout  (b_dout)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the selected instance pulses done or the limit expires.
    task automatic wait_done(input bit sel_b, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(sel_b ? b_done : a_done) && n < limit);
        check("done_seen", 32'(sel_b ? b_done : a_done), 32'd1);
    endtask

    // One-shot scan on the DWELL=2 instance with full per-edge checks.
    task automatic run_oneshot_a(input logic [15:0] word);
        a_in    = word;
        a_cont  = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("os_sw_start", 32'(a_sw), 32'd0);
        check("os_busy_start", 32'(a_busy), 32'd1);
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k < 32) begin
                check("os_sw_step", 32'(a_sw), 32'(k / 2));
                check("os_done_low", 32'(a_done), 32'd0);
            end else begin
                check("os_done_32", 32'(a_done), 32'd1);
                check("os_dout", 32'(a_dout), 32'(word));
                check("os_busy_end", 32'(a_busy), 32'd0);
                check("os_sw_end", 32'(a_sw), 32'd0);
            end
        end
        tick();
        check("os_done_pulse", 32'(a_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;

        // reset values
        #12;
        check("rst_sw", 32'(a_sw), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_dout", 32'(a_dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // scenario 1: one-shot A5C3
        run_oneshot_a(16'hA5C3);

        // one-hot walk in continuous mode, 32-cycle spacing without gaps
        a_in    = 16'h0001;
        a_cont  = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int s = 0; s < 16; s++) begin
            if (s == 15) a_cont = 1'b0;
            wait_done(1'b0, 40, n);
            check("walk_spacing", 32'(n), 32'd32);
            check("walk_dout", 32'(a_dout), 32'd1 << s);
            check("walk_busy", 32'(a_busy), (s < 15) ? 32'd1 : 32'd0);
            a_in = a_in << 1;
        end
        tick();
        check("walk_idle", 32'(a_busy), 32'd0);

        // DWELL=1: done at edge 16
        b_in    = 16'hFFFF;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_done(1'b1, 20, n);
        check("d1_latency", 32'(n), 32'd16);
        check("d1_dout", 32'(b_dout), 32'h0000FFFF);

        // DWELL=1, start held: each scan is one IDLE edge (start accepted) + 16 sample edges
        b_start = 1'b1;
        b_in    = 16'h5A5A;
        wait_done(1'b1, 25, n);
        check("held_spacing1", 32'(n), 32'd17);
        check("held_dout1", 32'(b_dout), 32'h00005A5A);
        b_in = 16'hC3C3;
        wait_done(1'b1, 25, n);
        check("held_spacing2", 32'(n), 32'd17);
        check("held_dout2", 32'(b_dout), 32'h0000C3C3);
        b_start = 1'b0;
        tick();
        check("held_idle", 32'(b_busy), 32'd0);

        // abort at edge 20
        run_oneshot_a(16'hA5C3);
        a_in    = 16'h1234;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (19) tick();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("abort_sw", 32'(a_sw), 32'd0);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        check("abort_dout", 32'(a_dout), 32'h0000A5C3);
        cnt = 0;
        repeat (40) begin
            tick();
            if (a_done) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);

        // abort coinciding with the last-sample edge
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (31) tick();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("abort_last_done", 32'(a_done), 32'd0);
        check("abort_last_dout", 32'(a_dout), 32'h0000A5C3);
        check("abort_last_busy", 32'(a_busy), 32'd0);
        tick();
        check("abort_last_done2", 32'(a_done), 32'd0);

        // start at edge 10 is ignored; done still at edge 32
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (9) tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_done(1'b0, 40, n);
        check("restart_latency", 32'(n), 32'd22);
        check("restart_dout", 32'(a_dout), 32'h00001234);
        tick();

        // asynchronous reset between edges
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (5) tick();
        check("pre_rst_sw", 32'(a_sw), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sw", 32'(a_sw), 32'd0);
        check("arst_busy", 32'(a_busy), 32'd0);
        check("arst_done", 32'(a_done), 32'd0);
        check("arst_dout", 32'(a_dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // first scan after reset release
        run_oneshot_a(16'hA5C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
